// File: rtl/regfile_wb_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
package regfile_wb_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LD,
    GNT_MD
  } grant_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Result-source, issue and RAM write-port signals of the write-back arbiter.
interface regfile_wb_arbiter_if;
  import regfile_wb_pkg::*;

  logic                alu_valid;
  logic [ADDR_W-1:0]   alu_dest;
  logic [DATA_W-1:0]   alu_data;
  logic                alu_stall;
  logic                ld_valid;
  logic                ld_ready;
  logic [ADDR_W-1:0]   ld_dest;
  logic [DATA_W-1:0]   ld_data;
  logic                md_valid;
  logic                md_ready;
  logic [ADDR_W-1:0]   md_dest;
  logic [DATA_W-1:0]   md_data;
  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_dest;
  logic [NUM_REGS-1:0] busy;
  logic                wren;
  logic [ADDR_W-1:0]   wraddress;
  logic [DATA_W-1:0]   data;

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  ld_valid, ld_dest, ld_data,
    input  md_valid, md_dest, md_data,
    input  issue_valid, issue_dest,
    output alu_stall, ld_ready, md_ready, busy, wren, wraddress, data
  );

  modport master (
    output alu_valid, alu_dest, alu_data,
    output ld_valid, ld_dest, ld_data,
    output md_valid, md_dest, md_data,
    output issue_valid, issue_dest,
    input  alu_stall, ld_ready, md_ready, busy, wren, wraddress, data
  );

endinterface

// File: rtl/wb_hold_slot.sv
// One-entry valid/ready result buffer; frees itself when granted and can refill in the same cycle.
module wb_hold_slot
  import regfile_wb_pkg::*;
(
  input  logic    clock,
  input  logic    resetn,
  input  wb_req_t in_req,
  input  logic    grant,
  output logic    ready,
  output wb_req_t held
);

  wb_req_t slot;

  assign ready = resetn && (!slot.valid || grant);
  assign held  = slot;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      slot <= '0;
    end else if (in_req.valid && ready) begin
      slot <= in_req;
    end else if (grant) begin
      slot.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU, load and mul/div results onto the single register-file write port.
// Optional busy scoreboard enabled by defining REGFILE_WB_SCOREBOARD_EN.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clock,
  input logic                 resetn,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

  wb_req_t             ld_in;
  wb_req_t             md_in;
  wb_req_t             ld_held;
  wb_req_t             md_held;
  wb_req_t             win;
  grant_t              gnt;
  logic                ld_gnt;
  logic                md_gnt;
  logic [WAIT_W-1:0]   md_wait;
  logic [WAIT_W-1:0]   md_wait_n;
  logic                starved;
  logic                wren_n;
  logic                wren_q;
  logic [ADDR_W-1:0]   wraddress_q;
  logic [DATA_W-1:0]   data_q;
  logic [NUM_REGS-1:0] busy_q;

  assign ld_in  = '{valid: bus.ld_valid, dest: bus.ld_dest, data: bus.ld_data};
  assign md_in  = '{valid: bus.md_valid, dest: bus.md_dest, data: bus.md_data};
  assign ld_gnt = (gnt == GNT_LD);
  assign md_gnt = (gnt == GNT_MD);

  wb_hold_slot u_ld_slot (
    .clock  (clock),
    .resetn (resetn),
    .in_req (ld_in),
    .grant  (ld_gnt),
    .ready  (bus.ld_ready),
    .held   (ld_held)
  );

  wb_hold_slot u_md_slot (
    .clock  (clock),
    .resetn (resetn),
    .in_req (md_in),
    .grant  (md_gnt),
    .ready  (bus.md_ready),
    .held   (md_held)
  );

  // Fixed priority with a starvation override for the mul/div slot.
  always_comb begin
    gnt = GNT_NONE;
    if (md_held.valid && starved) begin
      gnt = GNT_MD;
    end else if (bus.alu_valid && !starved) begin
      gnt = GNT_ALU;
    end else if (ld_held.valid) begin
      gnt = GNT_LD;
    end else if (md_held.valid) begin
      gnt = GNT_MD;
    end
  end

  always_comb begin
    win = '0;
    case (gnt)
      GNT_ALU: win = '{valid: 1'b1, dest: bus.alu_dest, data: bus.alu_data};
      GNT_LD:  win = ld_held;
      GNT_MD:  win = md_held;
      default: win = '0;
    endcase
  end

  always_comb begin
    md_wait_n = md_wait;
    if (!md_held.valid || md_gnt) begin
      md_wait_n = '0;
    end else if (md_wait < WAIT_W'(STARVE_LIMIT)) begin
      md_wait_n = md_wait + WAIT_W'(1);
    end
  end

  // A grant to r0 still drains its source but never reaches the RAM.
  assign wren_n = win.valid && (win.dest != ZERO_REG);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      md_wait     <= '0;
      starved     <= 1'b0;
      wren_q      <= 1'b0;
      wraddress_q <= '0;
      data_q      <= '0;
    end else begin
      md_wait <= md_wait_n;
      starved <= (md_wait_n >= WAIT_W'(STARVE_LIMIT));
      wren_q  <= wren_n;
      if (win.valid) begin
        wraddress_q <= win.dest;
        data_q      <= win.data;
      end
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_n;

  // Set after clear so a same-cycle issue to the register being written keeps it busy.
  always_comb begin
    busy_n = busy_q;
    if (wren_n) begin
      busy_n[win.dest] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_dest != ZERO_REG)) begin
      busy_n[bus.issue_dest] = 1'b1;
    end
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_n;
    end
  end
`else
  logic unused_issue;

  assign busy_q       = '0;
  assign unused_issue = bus.issue_valid ^ (^bus.issue_dest);
`endif

  assign bus.alu_stall = starved;
  assign bus.wren      = wren_q;
  assign bus.wraddress = wraddress_q;
  assign bus.data      = data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic clock;
  logic resetn;
  int   checks;
  int   failures;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  logic        m_ld_v, m_md_v;
  logic [4:0]  m_ld_dest, m_md_dest;
  logic [31:0] m_ld_data, m_md_data;
  int          m_md_wait;
  logic [31:0] m_busy;

  // Expectations and observations for the most recent cycle
  logic        exp_ld_ready, exp_md_ready, exp_alu_stall, exp_wren;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        obs_ld_ready, obs_md_ready, obs_alu_stall, obs_wren;
  logic [4:0]  obs_addr;
  logic [31:0] obs_data, obs_busy;
  logic        obs_rdy_in_reset;

  task automatic drive_idle();
    bus.alu_valid = 0; bus.alu_dest = 0; bus.alu_data = 0;
    bus.ld_valid = 0;  bus.ld_dest = 0;  bus.ld_data = 0;
    bus.md_valid = 0;  bus.md_dest = 0;  bus.md_data = 0;
    bus.issue_valid = 0; bus.issue_dest = 0;
  endtask

  task automatic model_clear();
    m_ld_v = 0; m_md_v = 0; m_ld_dest = 0; m_md_dest = 0; m_ld_data = 0; m_md_data = 0;
    m_md_wait = 0; m_busy = 0; exp_wren = 0; exp_addr = 0; exp_data = 0;
  endtask

  task automatic do_reset(input int n);
    resetn = 0;
    drive_idle();
    obs_rdy_in_reset = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      obs_rdy_in_reset = obs_rdy_in_reset | bus.ld_ready | bus.md_ready;
      @(posedge clock); #1;
    end
    resetn = 1;
    model_clear();
    obs_wren = bus.wren; obs_addr = bus.wraddress; obs_data = bus.data; obs_busy = bus.busy;
  endtask

  // One clock: apply inputs, advance the model from the arbitration rules, capture DUT outputs.
  task automatic step(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                      input logic lv, input logic [4:0] ld, input logic [31:0] ldat,
                      input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                      input logic iv, input logic [4:0] id);
    int          win;
    logic [4:0]  wd;
    logic [31:0] wdat;
    logic        starved;
    bus.alu_valid = av; bus.alu_dest = ad; bus.alu_data = adat;
    bus.ld_valid = lv;  bus.ld_dest = ld;  bus.ld_data = ldat;
    bus.md_valid = mv;  bus.md_dest = md;  bus.md_data = mdat;
    bus.issue_valid = iv; bus.issue_dest = id;
    @(negedge clock);
    obs_ld_ready = bus.ld_ready; obs_md_ready = bus.md_ready; obs_alu_stall = bus.alu_stall;
    starved = (m_md_wait >= LIMIT);
    exp_alu_stall = starved;
    if (m_md_v && starved) win = 3;
    else if (av && !starved) win = 1;
    else if (m_ld_v) win = 2;
    else if (m_md_v) win = 3;
    else win = 0;
    exp_ld_ready = !m_ld_v || (win == 2);
    exp_md_ready = !m_md_v || (win == 3);
    wd = 0; wdat = 0;
    if (win == 1) begin wd = ad; wdat = adat; end
    if (win == 2) begin wd = m_ld_dest; wdat = m_ld_data; end
    if (win == 3) begin wd = m_md_dest; wdat = m_md_data; end
    exp_wren = (win != 0) && (wd != 0);
    if (win != 0) begin exp_addr = wd; exp_data = wdat; end
    if (!m_md_v || win == 3) m_md_wait = 0;
    else if (m_md_wait < LIMIT) m_md_wait++;
    if (win == 2) m_ld_v = 0;
    if (win == 3) m_md_v = 0;
    if (lv && exp_ld_ready) begin m_ld_v = 1; m_ld_dest = ld; m_ld_data = ldat; end
    if (mv && exp_md_ready) begin m_md_v = 1; m_md_dest = md; m_md_data = mdat; end
`ifdef REGFILE_WB_SCOREBOARD_EN
    if (exp_wren) m_busy[wd] = 1'b0;
    if (iv && id != 0) m_busy[id] = 1'b1;
`endif
    @(posedge clock); #1;
    obs_wren = bus.wren; obs_addr = bus.wraddress; obs_data = bus.data; obs_busy = bus.busy;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++; if (obs_rdy_in_reset !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", obs_rdy_in_reset); end
    checks++; if (obs_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", obs_wren); end
    checks++; if (obs_addr !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", obs_addr); end
    checks++; if (obs_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", obs_data); end
    checks++; if (bus.alu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.alu_stall); end
    checks++; if (obs_busy !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", obs_busy); end
  endtask

  task automatic test_alu_single();
    step(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_wren !== 1'b1) begin failures++; $display("FAIL alu_wren got=%b exp=1", obs_wren); end
    checks++; if (obs_addr !== 5'd5) begin failures++; $display("FAIL alu_addr got=%0d exp=5", obs_addr); end
    checks++; if (obs_data !== 32'h1234_5678) begin failures++; $display("FAIL alu_data got=%h exp=12345678", obs_data); end
    idle();
    checks++; if (obs_wren !== 1'b0) begin failures++; $display("FAIL alu_idle_wren got=%b exp=0", obs_wren); end
  endtask

  task automatic test_alu_ld_same_cycle();
    step(1, 2, 32'hA, 1, 3, 32'hB, 0, 0, 0, 0, 0);
    checks++; if (obs_ld_ready !== 1'b1) begin failures++; $display("FAIL ld_ready_empty got=%b exp=1", obs_ld_ready); end
    checks++; if ({obs_wren, obs_addr, obs_data} !== {1'b1, 5'd2, 32'hA}) begin failures++;
      $display("FAIL alu_first got=%b/%0d/%h exp=1/2/a", obs_wren, obs_addr, obs_data); end
    idle();
    checks++; if (obs_ld_ready !== 1'b1) begin failures++; $display("FAIL ld_ready_granted got=%b exp=1", obs_ld_ready); end
    checks++; if ({obs_wren, obs_addr, obs_data} !== {1'b1, 5'd3, 32'hB}) begin failures++;
      $display("FAIL ld_second got=%b/%0d/%h exp=1/3/b", obs_wren, obs_addr, obs_data); end
    idle();
  endtask

  task automatic test_r0();
    step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_wren !== 1'b0) begin failures++; $display("FAIL r0_wren got=%b exp=0", obs_wren); end
    checks++; if (obs_busy[0] !== 1'b0) begin failures++; $display("FAIL r0_busy got=%b exp=0", obs_busy[0]); end
  endtask

  task automatic test_starvation();
    int stall_step;
    stall_step = -1;
    step(1, 1, 32'h11, 0, 0, 0, 1, 7, 32'h77, 0, 0);
    for (int i = 1; i <= 8 && stall_step < 0; i++) begin
      step(1, 1, 32'h100 + i, 0, 0, 0, 0, 0, 0, 0, 0);
      if (obs_alu_stall) begin
        stall_step = i;
        checks++; if ({obs_wren, obs_addr, obs_data} !== {1'b1, 5'd7, 32'h77}) begin failures++;
          $display("FAIL starve_md_write got=%b/%0d/%h exp=1/7/77", obs_wren, obs_addr, obs_data); end
      end
    end
    checks++; if (stall_step != 5) begin failures++; $display("FAIL starve_step got=%0d exp=5", stall_step); end
    step(1, 1, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_alu_stall !== 1'b0) begin failures++; $display("FAIL starve_stall_drop got=%b exp=0", obs_alu_stall); end
    checks++; if ({obs_wren, obs_addr, obs_data} !== {1'b1, 5'd1, 32'h55}) begin failures++;
      $display("FAIL starve_alu_resume got=%b/%0d/%h exp=1/1/55", obs_wren, obs_addr, obs_data); end
    idle();
  endtask

`ifdef REGFILE_WB_SCOREBOARD_EN
  task automatic test_scoreboard();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    checks++; if (obs_busy[9] !== 1'b1) begin failures++; $display("FAIL sb_set got=%b exp=1", obs_busy[9]); end
    step(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0, 0);
    checks++; if (obs_busy[9] !== 1'b1) begin failures++; $display("FAIL sb_hold got=%b exp=1", obs_busy[9]); end
    idle();
    checks++; if ({obs_wren, obs_addr, obs_busy[9]} !== {1'b1, 5'd9, 1'b0}) begin failures++;
      $display("FAIL sb_clear got=%b/%0d/%b exp=1/9/0", obs_wren, obs_addr, obs_busy[9]); end
    step(0, 0, 0, 1, 9, 32'h9A, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    checks++; if ({obs_wren, obs_addr, obs_busy[9]} !== {1'b1, 5'd9, 1'b1}) begin failures++;
      $display("FAIL sb_set_wins got=%b/%0d/%b exp=1/9/1", obs_wren, obs_addr, obs_busy[9]); end
  endtask
`endif

  task automatic test_reset_mid();
    step(1, 1, 32'h1, 1, 3, 32'hA, 1, 4, 32'hB, 1, 12);
    do_reset(1);
    checks++; if (obs_wren !== 1'b0) begin failures++; $display("FAIL midreset_wren got=%b exp=0", obs_wren); end
    checks++; if (obs_busy !== 32'd0) begin failures++; $display("FAIL midreset_busy got=%h exp=0", obs_busy); end
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (obs_wren !== 1'b0) begin failures++; $display("FAIL midreset_stale cycle=%0d got=%b exp=0", i, obs_wren); end
    end
  endtask

  task automatic test_random();
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)));
      checks++;
      if ({obs_ld_ready, obs_md_ready, obs_alu_stall} !== {exp_ld_ready, exp_md_ready, exp_alu_stall}) begin failures++;
        $display("FAIL rnd_handshake cycle=%0d got=%b%b%b exp=%b%b%b", i, obs_ld_ready, obs_md_ready, obs_alu_stall,
                 exp_ld_ready, exp_md_ready, exp_alu_stall); end
      checks++;
      if (obs_wren !== exp_wren || (exp_wren && (obs_addr !== exp_addr || obs_data !== exp_data))) begin failures++;
        $display("FAIL rnd_write cycle=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, obs_wren, obs_addr, obs_data,
                 exp_wren, exp_addr, exp_data); end
      checks++;
      if (obs_busy !== m_busy) begin failures++; $display("FAIL rnd_busy cycle=%0d got=%h exp=%h", i, obs_busy, m_busy); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 0;
    drive_idle();
    model_clear();
    test_reset();
    test_alu_single();
    test_alu_ld_same_cycle();
    test_r0();
    test_starvation();
`ifdef REGFILE_WB_SCOREBOARD_EN
    test_scoreboard();
`endif
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
